// File: rtl/vc_pkg.sv
// Shared constants and helpers for the VC attribute-bus transmit sequencer.
package vc_pkg;

    localparam int unsigned VC_W_DEF = 8;
    localparam int unsigned NUM_LYR  = 3;
    localparam int unsigned PHASE_W  = 3;

    localparam int unsigned LYR_FIX = 0;
    localparam int unsigned LYR_A   = 1;
    localparam int unsigned LYR_B   = 2;

    // All three receiver stages holding (active-low selects).
    localparam logic [2:0] SEL_IDLE = 3'b111;

    // Active-low select pattern for a slot: stages 1..slot+1 load, capped at the chain depth.
    function automatic logic [2:0] sel_mask(input logic [1:0] slot, input int unsigned stages);
        logic [2:0] m;
        m    = SEL_IDLE;
        m[0] = ~(stages >= 32'd1);
        m[1] = ~((slot >= 2'd1) && (stages >= 32'd2));
        m[2] = ~((slot >= 2'd2) && (stages >= 32'd3));
        return m;
    endfunction

endpackage

// File: rtl/vc_slot_sched.sv
// Tile phase counter with TILE_SYNC resync, plus tile-boundary and slot decode.
module vc_slot_sched
    import vc_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned SLOT0  = 2
) (
    input  logic       ck_i,
    input  logic       rst_i,
    input  logic       pixce_i,
    input  logic       tile_sync_i,
    output logic       boundary_o,
    output logic       slot_valid_o,
    output logic [1:0] slot_idx_o
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // Next phase: advance on PIXCE, TILE_SYNC forces a new tile.
    always_comb begin
        phase_d = phase_q;
        if (pixce_i) begin
            phase_d = tile_sync_i ? '0 : phase_q + 3'd1;
        end
    end

    // Phase register.
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Decode against the phase being entered on this PIXCE edge.
    always_comb begin
        boundary_o   = pixce_i && (phase_d == '0);
        slot_valid_o = pixce_i
                       && (phase_d >= PHASE_W'(SLOT0))
                       && ({1'b0, phase_d} < 4'(SLOT0 + STAGES));
        slot_idx_o   = 2'(phase_d - PHASE_W'(SLOT0));
    end

endmodule

// File: rtl/vc_out_seq.sv
// Transmit sequencer: accepts one attribute set per tile and serialises it onto
// the VC bus with the per-stage load selects for the receiving delay chain.
module vc_out_seq
    import vc_pkg::*;
#(
    parameter int unsigned     STAGES  = 3,
    parameter int unsigned     VC_W    = VC_W_DEF,
    parameter int unsigned     SLOT0   = 2,
    parameter logic [VC_W-1:0] IDLE_VC = '0
) (
    input  logic            ck_i,
    input  logic            rst_i,
    input  logic            pixce_i,
    input  logic            tile_sync_i,
    input  logic            attr_valid_i,
    output logic            attr_ready_o,
    input  logic [VC_W-1:0] attr_fix_i,
    input  logic [VC_W-1:0] attr_a_i,
    input  logic [VC_W-1:0] attr_b_i,
    output logic [VC_W-1:0] vc_o,
    output logic            sel1_n_o,
    output logic            sel2_n_o,
    output logic            sel3_n_o,
    output logic            underrun_o
);

    logic       boundary;
    logic       slot_valid;
    logic [1:0] slot_idx;

    vc_slot_sched #(
        .STAGES (STAGES),
        .SLOT0  (SLOT0)
    ) u_sched (
        .ck_i         (ck_i),
        .rst_i        (rst_i),
        .pixce_i      (pixce_i),
        .tile_sync_i  (tile_sync_i),
        .boundary_o   (boundary),
        .slot_valid_o (slot_valid),
        .slot_idx_o   (slot_idx)
    );

    logic                         full_q,     full_d;
    logic                         armed_q,    armed_d;
    logic [NUM_LYR-1:0][VC_W-1:0] hold_q,     hold_d;
    logic [NUM_LYR-1:0][VC_W-1:0] send_q,     send_d;
    logic [VC_W-1:0]              vc_q,       vc_d;
    logic [2:0]                   sel_q,      sel_d;
    logic                         underrun_q, underrun_d;

    logic                         accept;
    logic                         src_armed;
    logic [NUM_LYR-1:0][VC_W-1:0] src;
    logic [1:0]                   lyr;

    // Handshake, boundary transfer/underrun decision and slot output generation.
    always_comb begin
        full_d     = full_q;
        armed_d    = armed_q;
        hold_d     = hold_q;
        send_d     = send_q;
        vc_d       = vc_q;
        sel_d      = SEL_IDLE;
        underrun_d = 1'b0;
        src        = send_q;
        src_armed  = armed_q;
        lyr        = 2'(STAGES - 1) - slot_idx;
        accept     = attr_valid_i && !full_q;

        if (boundary) begin
            if (full_q) begin
                send_d  = hold_q;
                full_d  = 1'b0;
                armed_d = 1'b1;
            end else begin
                underrun_d = 1'b1;
                armed_d    = 1'b0;
            end
            // A slot landing on the boundary edge itself (SLOT0 = 0) uses the set being armed now.
            src       = hold_q;
            src_armed = full_q;
        end

        // Captured data always waits for the next boundary; no bypass into send.
        if (accept) begin
            hold_d[LYR_FIX] = attr_fix_i;
            hold_d[LYR_A]   = attr_a_i;
            hold_d[LYR_B]   = attr_b_i;
            full_d          = 1'b1;
        end

        if (slot_valid && src_armed) begin
            vc_d  = src[lyr];
            sel_d = sel_mask(slot_idx, STAGES);
        end
    end

    // State and output registers; selects default back to idle every edge.
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            full_q     <= 1'b0;
            armed_q    <= 1'b0;
            hold_q     <= '0;
            send_q     <= '0;
            vc_q       <= IDLE_VC;
            sel_q      <= SEL_IDLE;
            underrun_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
            send_q     <= send_d;
            vc_q       <= vc_d;
            sel_q      <= sel_d;
            underrun_q <= underrun_d;
        end
    end

    assign attr_ready_o = ~full_q;
    assign vc_o         = vc_q;
    assign sel1_n_o     = sel_q[0];
    assign sel2_n_o     = sel_q[1];
    assign sel3_n_o     = sel_q[2];
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_vc_out_seq.sv
// Bench for vc_out_seq: two instances (3 stages/slot0 2, 1 stage/slot0 7) on shared stimulus,
// a per-cycle behavioural model, receiver chain models and directed literal checks.
`timescale 1ns/1ps
module tb_vc_out_seq;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       pixce = 1'b0;
    logic       ts = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] fix = 8'h00, a = 8'h00, b = 8'h00;

    logic       rdy3, rdy1, und3, und1;
    logic       s31, s32, s33, s11, s12, s13;
    logic [7:0] vc3, vc1;

    always #5 ck = ~ck;

    vc_out_seq #(.STAGES(3), .VC_W(8), .SLOT0(2), .IDLE_VC(8'h00)) u3 (
        .ck_i(ck), .rst_i(rst), .pixce_i(pixce), .tile_sync_i(ts),
        .attr_valid_i(valid), .attr_ready_o(rdy3),
        .attr_fix_i(fix), .attr_a_i(a), .attr_b_i(b),
        .vc_o(vc3), .sel1_n_o(s31), .sel2_n_o(s32), .sel3_n_o(s33), .underrun_o(und3)
    );

    vc_out_seq #(.STAGES(1), .VC_W(8), .SLOT0(7), .IDLE_VC(8'h00)) u1 (
        .ck_i(ck), .rst_i(rst), .pixce_i(pixce), .tile_sync_i(ts),
        .attr_valid_i(valid), .attr_ready_o(rdy1),
        .attr_fix_i(fix), .attr_a_i(a), .attr_b_i(b),
        .vc_o(vc1), .sel1_n_o(s11), .sel2_n_o(s12), .sel3_n_o(s13), .underrun_o(und1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0: u3, index 1: u1) ----------------
    int          st [2] = '{3, 1};
    int          s0 [2] = '{2, 7};
    int          m_phase [2];
    bit          m_pend_v [2];
    logic [23:0] m_pend [2];
    bit          m_cur_v [2];
    logic [23:0] m_cur [2];
    logic [7:0]  e_vc [2];
    logic [2:0]  e_sel [2];
    bit          e_und [2];

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_pend_v[i] = 0; m_cur_v[i] = 0;
                m_pend[i] = '0; m_cur[i] = '0;
                e_vc[i] = 8'h00; e_sel[i] = 3'b111; e_und[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit acc;
                int np;
                int s;
                acc = valid && !m_pend_v[i];
                e_sel[i] = 3'b111;
                e_und[i] = 0;
                if (pixce) begin
                    np = ts ? 0 : (m_phase[i] + 1) % 8;
                    if (np == 0) begin
                        m_cur_v[i]  = m_pend_v[i];
                        m_cur[i]    = m_pend[i];
                        e_und[i]    = !m_pend_v[i];
                        m_pend_v[i] = 0;
                    end
                    m_phase[i] = np;
                    s = np - s0[i];
                    if (m_cur_v[i] && s >= 0 && s < st[i]) begin
                        e_vc[i] = m_cur[i][8*(st[i]-1-s) +: 8];
                        for (int k = 1; k <= 3; k++)
                            e_sel[i][k-1] = !(k <= s + 1 && k <= st[i]);
                    end
                end
                if (acc) begin
                    m_pend[i]   = {b, a, fix};
                    m_pend_v[i] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare, receivers, event logs ----------------
    bit          cmp_en = 0;
    logic [7:0]  r3_1 = 0, r3_2 = 0, r3_3 = 0, r1_1 = 0;
    logic [10:0] ev3 [$];
    logic [10:0] ev1 [$];
    int          und3_cnt = 0, und1_cnt = 0, acc_cnt = 0;
    bit          bad1 = 0;

    always @(negedge ck) begin
        logic [7:0] n1, n2, n3;
        if (cmp_en && !rst) begin
            chk("vc_s3",  32'(vc3), 32'(e_vc[0]));
            chk("sel_s3", 32'({s33, s32, s31}), 32'(e_sel[0]));
            chk("und_s3", 32'(und3), 32'(e_und[0]));
            chk("rdy_s3", 32'(rdy3), 32'(!m_pend_v[0]));
            chk("vc_s1",  32'(vc1), 32'(e_vc[1]));
            chk("sel_s1", 32'({s13, s12, s11}), 32'(e_sel[1]));
            chk("und_s1", 32'(und1), 32'(e_und[1]));
            chk("rdy_s1", 32'(rdy1), 32'(!m_pend_v[1]));
            if ({s33, s32, s31} != 3'b111) ev3.push_back({s33, s32, s31, vc3});
            if ({s13, s12, s11} != 3'b111) ev1.push_back({s13, s12, s11, vc1});
            if (und3) und3_cnt++;
            if (und1) und1_cnt++;
            if (!s12 || !s13) bad1 = 1;
            if (valid && rdy3) acc_cnt++;
        end
        // Receiver chains load on the coming CK edge from the values present now.
        n1 = !s31 ? vc3 : r3_1;
        n2 = !s32 ? r3_1 : r3_2;
        n3 = !s33 ? r3_2 : r3_3;
        r3_1 = n1; r3_2 = n2; r3_3 = n3;
        if (!s11) r1_1 = vc1;
    end

    // ---------------- stimulus helpers ----------------
    logic [10:0] exp_ev [5];

    task automatic cyc(input bit p, input bit t);
        pixce = p; ts = t;
        @(posedge ck); #1;
        pixce = 0; ts = 0;
    endtask

    task automatic pix4(input bit t);
        cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, t);
    endtask

    task automatic pix4n(input int n);
        for (int j = 0; j < n; j++) pix4(0);
    endtask

    task automatic send(input logic [7:0] f, input logic [7:0] aa, input logic [7:0] bb);
        fix = f; a = aa; b = bb; valid = 1;
        cyc(0, 0);
        valid = 0;
    endtask

    task automatic ev_check(input string nm, input bit one, input int n);
        int sz;
        sz = one ? ev1.size() : ev3.size();
        chk({nm, "_count"}, 32'(sz), 32'(n));
        for (int j = 0; j < n && j < sz; j++)
            chk($sformatf("%s_%0d", nm, j), 32'(one ? ev1[j] : ev3[j]), 32'(exp_ev[j]));
    endtask

    task automatic ev_clear();
        ev3.delete(); ev1.delete(); und3_cnt = 0; und1_cnt = 0;
    endtask

    initial begin
        repeat (3) @(posedge ck);
        #1 rst = 0;
        cmp_en = 1;

        // Reset state.
        chk("rst_vc", 32'(vc3), 32'h00);
        chk("rst_sel", 32'({s33, s32, s31}), 32'h7);
        chk("rst_rdy", 32'(rdy3), 32'h1);
        chk("rst_und", 32'(und3), 32'h0);

        // First tile: FIX/A/B = 11/22/33, PIXCE every 4th CK.
        send(8'h11, 8'h22, 8'h33);
        chk("rdy_fall", 32'(rdy3), 32'h0);
        ev_clear();
        pix4n(8);
        chk("no_bypass_ev", 32'(ev3.size()), 32'h0);
        chk("rdy_rise", 32'(rdy3), 32'h1);
        pix4n(7); cyc(0, 0);
        exp_ev[0] = {3'b110, 8'h33}; exp_ev[1] = {3'b100, 8'h22}; exp_ev[2] = {3'b000, 8'h11};
        ev_check("t1_s3", 0, 3);
        exp_ev[0] = {3'b110, 8'h11};
        ev_check("t1_s1", 1, 1);
        chk("t1_rx1", 32'(r3_1), 32'h11);
        chk("t1_rx2", 32'(r3_2), 32'h22);
        chk("t1_rx3", 32'(r3_3), 32'h33);
        chk("t1_rxs1", 32'(r1_1), 32'h11);

        // Underrun tile.
        ev_clear();
        pix4n(8); cyc(0, 0);
        chk("ur_cnt_s3", 32'(und3_cnt), 32'h1);
        chk("ur_cnt_s1", 32'(und1_cnt), 32'h1);
        chk("ur_ev", 32'(ev3.size() + ev1.size()), 32'h0);
        chk("ur_rx1", 32'(r3_1), 32'h11);
        chk("ur_rx3", 32'(r3_3), 32'h33);

        // TILE_SYNC during slot 1 with the next set pending.
        ev_clear();
        send(8'hAA, 8'hBB, 8'hCC);
        pix4(0);
        send(8'hDD, 8'hEE, 8'hFF);
        pix4n(3);
        pix4(1);
        pix4n(7); cyc(0, 0);
        exp_ev[0] = {3'b110, 8'hCC}; exp_ev[1] = {3'b100, 8'hBB};
        exp_ev[2] = {3'b110, 8'hFF}; exp_ev[3] = {3'b100, 8'hEE}; exp_ev[4] = {3'b000, 8'hDD};
        ev_check("ts_s3", 0, 5);
        exp_ev[0] = {3'b110, 8'hDD};
        ev_check("ts_s1", 1, 1);
        chk("ts_rx1", 32'(r3_1), 32'hDD);
        chk("ts_rx2", 32'(r3_2), 32'hEE);
        chk("ts_rx3", 32'(r3_3), 32'hFF);

        // Reset asserted during slot 1.
        send(8'h12, 8'h34, 8'h56);
        pix4(0);
        send(8'h78, 8'h9A, 8'hBC);
        pix4n(3);
        chk("pre_rst_sel", 32'({s33, s32, s31}), 32'h4);
        chk("pre_rst_vc", 32'(vc3), 32'h34);
        #2 rst = 1;
        #1;
        chk("arst_vc3", 32'(vc3), 32'h00);
        chk("arst_vc1", 32'(vc1), 32'h00);
        chk("arst_sel", 32'({s33, s32, s31}), 32'h7);
        chk("arst_rdy", 32'(rdy3), 32'h1);
        @(posedge ck); @(posedge ck); #1 rst = 0;
        ev_clear();
        send(8'h21, 8'h43, 8'h65);
        pix4n(8); pix4n(7); cyc(0, 0);
        exp_ev[0] = {3'b110, 8'h65}; exp_ev[1] = {3'b100, 8'h43}; exp_ev[2] = {3'b000, 8'h21};
        ev_check("rr_s3", 0, 3);
        exp_ev[0] = {3'b110, 8'h21};
        ev_check("rr_s1", 1, 1);
        chk("rr_rx1", 32'(r3_1), 32'h21);
        chk("rr_rx3", 32'(r3_3), 32'h65);

        // PIXCE every CK with a continuously valid source: one accept per tile.
        acc_cnt = 0;
        valid = 1;
        for (int j = 0; j < 48; j++) begin
            fix = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
            cyc(1, 0);
        end
        valid = 0;
        chk("b2b_accepts", 32'(acc_cnt), 32'd6);

        // Randomised traffic.
        for (int j = 0; j < 800; j++) begin
            fix = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
            valid = ($urandom % 3) == 0;
            pixce = ($urandom % 2) == 0;
            ts = ($urandom % 37) == 0;
            @(posedge ck); #1;
        end
        valid = 0; pixce = 0; ts = 0;
        cyc(0, 0);
        chk("s1_sel23_never_low", 32'(bad1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
